regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 32, register data width.
REQ-002 SHALL have parameter ADDR_W, 5, register address width; the register count is 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-006 SHALL have port iss_valid  input  1  decode is issuing an instruction that writes iss_rd.
REQ-007 SHALL have port iss_rd  input  ADDR_W  destination register of the issuing instruction.
REQ-008 SHALL have ports rs1_re, rs2_re  input  1 each  source-operand read enables.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  ADDR_W each  source-operand addresses.
REQ-010 SHALL have port stall  output  1  combinational; decode must hold this cycle.
REQ-011 SHALL have ports a_valid/a_rd/a_data  input  1/ADDR_W/DATA_W  ALU writeback request.
REQ-012 SHALL have port a_ready  output  1  ALU writeback accepted this cycle.
REQ-013 SHALL have ports b_valid/b_rd/b_data  input  1/ADDR_W/DATA_W  load/store writeback request.
REQ-014 SHALL have port b_ready  output  1  load/store writeback accepted this cycle.
REQ-015 SHALL have ports we/waddr/wdata  output  1/ADDR_W/DATA_W  registered drive of the register-file write port.

Function
REQ-016 SHALL complete a writeback transfer on source X only in a cycle where X_valid, X_ready and rdy are all high; the requester holds X_rd and X_data stable until then.
REQ-017 SHALL assert at most one of a_ready/b_ready per cycle; both are 0 while rdy is low.
REQ-018 SHALL arbitrate as follows: only one valid -> grant it; both valid -> grant the source not granted in the last transfer (round-robin, 1-bit last_grant pointer, updated only on a transfer).
REQ-019 SHALL register the granted request with 1-cycle latency: transfer in cycle N gives we=1, waddr=X_rd, wdata=X_data in cycle N+1.
REQ-020 SHALL drive we=0 in any cycle following a cycle with no transfer; waddr/wdata then hold their last values.
REQ-021 SHALL accept a transfer with X_rd=0 (ready asserted normally) but SHALL keep we=0 for it.
REQ-022 SHALL keep a pending vector with one bit per register; bit 0 is constantly 0.
REQ-023 SHALL set pending[iss_rd] at the edge ending a cycle with iss_valid=1, stall=0, rdy=1 and iss_rd!=0.
REQ-024 SHALL clear pending[waddr] at the edge ending a cycle with we=1 and rdy=1.
REQ-025 SHALL let set win over clear when both target the same register in the same cycle.
REQ-026 SHALL leave pending unchanged for a writeback to a register that is not pending; the write is still performed.
REQ-027 SHALL raise stall for a RAW hazard: rsK_re=1, rsK_addr!=0, pending[rsK_addr]=1 and not (we=1 and waddr=rsK_addr); the last term covers register-file write forwarding.
REQ-028 SHALL raise stall for a WAW hazard: iss_valid=1, iss_rd!=0, pending[iss_rd]=1 and not (we=1 and waddr=iss_rd).
REQ-029 SHALL hold the pending vector, last_grant and all write-port registers unchanged while rdy=0.

Reset
REQ-030 SHALL, while rst=0 and independent of clk, force we=0, waddr=0, wdata=0, pending=all-zero and last_grant=B, so source A wins the first tie.
REQ-031 SHALL discard all in-flight requests on reset; requesters must re-present them after reset is released.
REQ-032 SHALL resume normal operation at the first rising edge with rst=1.

Verification
REQ-033 Tie: after reset, a_valid=b_valid=1 held for 4 cycles -> grants A,B,A,B; we=1 on cycles 2-5 with the matching rd/data.
REQ-034 RAW: issue rd=5; next cycle rs1_addr=5, rs1_re=1 -> stall=1; A writes rd=5 -> stall=0 in the we=1 cycle; pending[5]=0 afterwards.
REQ-035 WAW plus set-over-clear: pending[7]=1, iss_rd=7 -> stall=1; in the cycle with we=1 and waddr=7 -> stall=0, issue accepted, pending[7] stays 1.
REQ-036 x0: b_rd=0, b_valid=1 -> b_ready=1, we stays 0; rs2_addr=0 never stalls.
REQ-037 rdy freeze: rdy=0 for 3 cycles with both sources valid -> no ready asserted, pending and last_grant unchanged; resumes on rdy=1.
REQ-038 Async reset: assert rst=0 mid-cycle while we=1 and pending=0x0000_00A0 -> we=0 and pending=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin arbitration between the ALU and load/store
// writeback ports, a registered write port, and scoreboard-based RAW/WAW stall generation.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic              rs1_re,
   input  logic              rs2_re,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              stall,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata
);

   localparam int NREG = 2 ** ADDR_W;

   logic [NREG-1:0]   r_pending;
   logic              r_last_b;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_grant_a;
   logic              w_grant_b;
   logic              w_xfer;
   logic [ADDR_W-1:0] w_sel_rd;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_raw1;
   logic              w_raw2;
   logic              w_waw;
   logic              w_issue;
   logic [NREG-1:0]   w_pending_nxt;

   // On a tie the source that did not win the previous transfer is granted.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (rdy) begin
         if (a_valid && b_valid) begin
            w_grant_a = r_last_b;
            w_grant_b = ~r_last_b;
         end else begin
            w_grant_a = a_valid;
            w_grant_b = b_valid;
         end
      end
   end

   assign a_ready    = w_grant_a;
   assign b_ready    = w_grant_b;
   assign w_xfer     = w_grant_a | w_grant_b;
   assign w_sel_rd   = w_grant_b ? b_rd   : a_rd;
   assign w_sel_data = w_grant_b ? b_data : a_data;

   // A register being written this cycle is forwarded by the register file, so it never stalls.
   assign w_raw1 = rs1_re && (rs1_addr != '0) && r_pending[rs1_addr]
                   && !(r_we && (r_waddr == rs1_addr));
   assign w_raw2 = rs2_re && (rs2_addr != '0) && r_pending[rs2_addr]
                   && !(r_we && (r_waddr == rs2_addr));
   assign w_waw  = iss_valid && (iss_rd != '0) && r_pending[iss_rd]
                   && !(r_we && (r_waddr == iss_rd));

   assign stall   = w_raw1 | w_raw2 | w_waw;
   assign w_issue = iss_valid && !stall && rdy && (iss_rd != '0);

   // Clear is applied first so a same-register issue leaves the bit set.
   always_comb begin
      w_pending_nxt = r_pending;
      if (r_we) begin
         w_pending_nxt[r_waddr] = 1'b0;
      end
      if (w_issue) begin
         w_pending_nxt[iss_rd] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= '0;
         r_last_b  <= 1'b1;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
      end else if (rdy) begin
         r_pending <= w_pending_nxt;
         r_we      <= w_xfer && (w_sel_rd != '0);
         if (w_xfer) begin
            r_waddr  <= w_sel_rd;
            r_wdata  <= w_sel_data;
            r_last_b <= w_grant_b;
         end
      end
   end

   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed hazard/arbitration scenarios followed by
// randomized traffic, checked against a behavioural model of pending registers and grants.
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic          rdy;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic          rs1_re;
   logic          rs2_re;
   logic [AW-1:0] rs1_addr;
   logic [AW-1:0] rs2_addr;
   logic          stall;
   logic          a_valid;
   logic [AW-1:0] a_rd;
   logic [DW-1:0] a_data;
   logic          a_ready;
   logic          b_valid;
   logic [AW-1:0] b_rd;
   logic [DW-1:0] b_data;
   logic          b_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .rs1_re(rs1_re), .rs2_re(rs2_re), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .stall(stall),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .we(we), .waddr(waddr), .wdata(wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           sb_q[$];
   wr_t           mon_e;
   bit            mon_en;
   int            checks;
   int            errors;

   // Behavioural model state
   bit [31:0]     m_pend;
   bit            m_last_b;
   bit            m_we;
   bit [AW-1:0]   m_waddr;
   bit [DW-1:0]   m_wdata;
   bit            acc_a;
   bit            acc_b;
   int            next_rd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hazard(input logic en, input logic [AW-1:0] r);
      return en && (r != 0) && m_pend[r] && !(m_we && (m_waddr == r));
   endfunction

   task automatic model_reset();
      mon_en   = 1'b0;
      sb_q.delete();
      m_pend   = '0;
      m_last_b = 1'b1;
      m_we     = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
      acc_a    = 1'b0;
      acc_b    = 1'b0;
   endtask

   task automatic clear_inputs();
      rdy = 1'b1; iss_valid = 1'b0; iss_rd = '0;
      rs1_re = 1'b0; rs2_re = 1'b0; rs1_addr = '0; rs2_addr = '0;
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
   endtask

   // Called right after inputs are driven at a falling edge: checks combinational outputs,
   // advances the model across the coming rising edge and queues the expected write port.
   task automatic step();
      bit es;
      int g;
      mon_en = 1'b1;
      #1;
      es = hazard(rs1_re, rs1_addr) || hazard(rs2_re, rs2_addr) || hazard(iss_valid, iss_rd);
      g = 0;
      if (rdy) begin
         if (a_valid && b_valid) g = m_last_b ? 1 : 2;
         else if (a_valid)       g = 1;
         else if (b_valid)       g = 2;
      end
      chk("stall", stall, es);
      chk("a_ready", a_ready, (g == 1));
      chk("b_ready", b_ready, (g == 2));
      acc_a = (g == 1);
      acc_b = (g == 2);
      if (rdy) begin
         if (m_we) m_pend[m_waddr] = 1'b0;
         if (iss_valid && !es && (iss_rd != 0)) m_pend[iss_rd] = 1'b1;
         if (g == 1) begin
            m_last_b = 1'b0; m_we = (a_rd != 0); m_waddr = a_rd; m_wdata = a_data;
         end else if (g == 2) begin
            m_last_b = 1'b1; m_we = (b_rd != 0); m_waddr = b_rd; m_wdata = b_data;
         end else begin
            m_we = 1'b0;
         end
      end
      sb_q.push_back('{we: m_we, addr: m_waddr, data: m_wdata});
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got we=%0b with no expected entry at %0t", we, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("we", we, mon_e.we);
            chk("waddr", waddr, mon_e.addr);
            chk("wdata", wdata, mon_e.data);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      next_rd = 1;
      model_reset();
      clear_inputs();
      rst = 1'b0;
      #1;
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Tie: grants alternate A,B,A,B starting with A
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!a_valid || acc_a) begin
            a_valid = 1'b1; a_rd = AW'(next_rd); a_data = $urandom; next_rd++;
         end
         if (!b_valid || acc_b) begin
            b_valid = 1'b1; b_rd = AW'(next_rd); b_data = $urandom; next_rd++;
         end
         step();
         chk("tie_grant_a", a_ready, (i % 2 == 0));
      end

      // RAW on x5 with forwarding
      @(negedge clk); clear_inputs(); iss_valid = 1'b1; iss_rd = 5'd5; step();
      chk("raw_issue", stall, 0);
      @(negedge clk); iss_valid = 1'b0; rs1_re = 1'b1; rs1_addr = 5'd5; step();
      chk("raw_stall", stall, 1);
      @(negedge clk); a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h5555_0005; step();
      @(negedge clk); a_valid = 1'b0; step();
      chk("raw_fwd", stall, 0);
      @(negedge clk); step();
      chk("raw_clr", stall, 0);

      // WAW on x7 with set-over-clear
      @(negedge clk); clear_inputs(); iss_valid = 1'b1; iss_rd = 5'd7; step();
      @(negedge clk); step();
      chk("waw_stall", stall, 1);
      @(negedge clk); a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h7777_0007; step();
      @(negedge clk); a_valid = 1'b0; step();
      chk("waw_fwd", stall, 0);
      @(negedge clk); iss_valid = 1'b0; rs1_re = 1'b1; rs1_addr = 5'd7; step();
      chk("waw_still_pend", stall, 1);

      // x0 writeback and x0 source
      @(negedge clk); clear_inputs(); b_valid = 1'b1; b_rd = '0; b_data = 32'hDEAD_0000;
      rs2_re = 1'b1; rs2_addr = '0; step();
      chk("x0_ready", b_ready, 1);
      chk("x0_nostall", stall, 0);
      @(negedge clk); b_valid = 1'b0; step();
      chk("x0_we", we, 0);

      // rdy freeze with both sources waiting
      @(negedge clk); clear_inputs(); rdy = 1'b0;
      a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA0A0_000A;
      b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hB0B0_000B;
      step();
      chk("frz_ready", {a_ready, b_ready}, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); step();
         chk("frz_ready", {a_ready, b_ready}, 0);
      end
      @(negedge clk); rdy = 1'b1; step();
      chk("resume_a", a_ready, 1);
      @(negedge clk); a_valid = 1'b0; step();
      chk("resume_b", b_ready, 1);

      // Asynchronous reset while a write is on the port and x5/x7 are pending
      @(negedge clk); clear_inputs(); iss_valid = 1'b1; iss_rd = 5'd5; step();
      @(negedge clk); iss_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h9999_0009; step();
      @(negedge clk); a_valid = 1'b0; rs1_re = 1'b1; rs1_addr = 5'd7;
      rs2_re = 1'b1; rs2_addr = 5'd5; step();
      chk("pre_rst_we", we, 1);
      chk("pre_rst_stall", stall, 1);
      mon_en = 1'b0;
      sb_q.delete();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_we", we, 0);
      chk("arst_waddr", waddr, 0);
      chk("arst_stall", stall, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      clear_inputs();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rdy = ($urandom_range(0, 7) != 0);
         if (!a_valid || acc_a) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_rd    = AW'($urandom_range(0, 7));
            a_data  = $urandom;
         end
         if (!b_valid || acc_b) begin
            b_valid = ($urandom_range(0, 2) != 0);
            b_rd    = AW'($urandom_range(0, 7));
            b_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_rd    = AW'($urandom_range(0, 7));
         rs1_re    = ($urandom_range(0, 1) != 0);
         rs1_addr  = AW'($urandom_range(0, 7));
         rs2_re    = ($urandom_range(0, 1) != 0);
         rs2_addr  = AW'($urandom_range(0, 7));
         step();
      end

      @(negedge clk);
      mon_en = 1'b0;
      chk("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
